cam_frame_writer: RTL and testbench

Write-DMA stage directly downstream of the camera stream buffer. Consumes the 64-bit pixel stream (`sdata`/`sdata_valid`/`sdata_burst_valid`/`sdata_ready`) on `fclk`. Packs it into fixed 16-beat AXI3 write bursts to a frame buffer in DDR. Reports frame completion and bus errors to the control/register block.

---
 rtl/cam_frame_writer_if.sv | 35 +++
 rtl/cam_frame_writer.sv | 167 ++++++++++++++++
 tb/tb_cam_frame_writer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_frame_writer_if.sv
// AXI3 write-channel bundle between the frame writer (master) and the DDR port (slave).
interface cam_frame_writer_if;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cam_frame_writer.sv
// Write-DMA stage: packs the camera pixel stream into fixed-length AXI3 INCR bursts
// into a DDR frame buffer, tracking outstanding responses and reporting done/err.
module cam_frame_writer #(
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               fclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [23:0]        frame_bursts,
  input  logic [63:0]        sdata,
  input  logic               sdata_valid,
  input  logic               sdata_burst_valid,
  output logic               sdata_ready,
  cam_frame_writer_if.master axi,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [23:0]        bursts_done
);
  localparam int            BURST_SHIFT = $clog2(BURST_LEN * 8);
  localparam int            OW          = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0]    LAST_BEAT   = 4'(BURST_LEN - 1);
  localparam logic [OW-1:0] MAX_OUT     = OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, ADDR, DATA, DRAIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          done_nxt;
  logic [31:0]   base_q;
  logic [23:0]   frame_q;
  logic [23:0]   issued;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [3:0]    beat;
  logic          start_ok;
  logic          misaligned;
  logic          empty_frame;
  logic          aw_fire;
  logic          w_fire;
  logic          b_fire;

  always_comb begin
    start_ok        = (state == IDLE) && start;
    misaligned      = base_addr[BURST_SHIFT-1:0] != '0;
    empty_frame     = frame_bursts == '0;
    aw_fire         = (state == ADDR) && axi.awready;
    w_fire          = (state == DATA) && sdata_valid && axi.wready;
    b_fire          = (outstanding != '0) && axi.bvalid;
    outstanding_nxt = outstanding;
    if (aw_fire && !b_fire) begin
      outstanding_nxt = outstanding + OW'(1);
    end else if (b_fire && !aw_fire) begin
      outstanding_nxt = outstanding - OW'(1);
    end
  end

  // DRAIN raises done once the last response lands, then holds one more cycle so
  // busy stays high through the done pulse.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned || empty_frame) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (issued == frame_q) begin
          state_nxt = DRAIN;
        end else if (sdata_burst_valid && (outstanding < MAX_OUT)) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (axi.awready) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_fire && (beat == LAST_BEAT)) begin
          state_nxt = WAIT_DATA;
        end
      end
      DRAIN: begin
        if (done) begin
          state_nxt = IDLE;
        end else if (outstanding_nxt == '0) begin
          done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      frame_q     <= '0;
      issued      <= '0;
      outstanding <= '0;
      beat        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (start_ok) begin
        base_q  <= base_addr;
        frame_q <= frame_bursts;
        issued  <= '0;
      end else if (aw_fire) begin
        issued <= issued + 24'd1;
      end
      if (aw_fire) begin
        beat <= '0;
      end else if (w_fire) begin
        beat <= beat + 4'd1;
      end
    end
  end

  // A bad response only flags err; the frame keeps running to completion.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      err         <= 1'b0;
      bursts_done <= '0;
    end else if (start_ok) begin
      err         <= misaligned;
      bursts_done <= '0;
    end else if (b_fire) begin
      bursts_done <= bursts_done + 24'd1;
      if (axi.bresp != 2'b00) begin
        err <= 1'b1;
      end
    end
  end

  assign axi.awvalid = (state == ADDR);
  assign axi.awaddr  = (state == ADDR) ? base_q + ({8'd0, issued} << BURST_SHIFT) : '0;
  assign axi.awlen   = LAST_BEAT;
  assign axi.awsize  = 3'd3;
  assign axi.awburst = 2'b01;

  assign axi.wvalid  = (state == DATA) && sdata_valid;
  assign axi.wdata   = sdata;
  assign axi.wstrb   = 8'hFF;
  assign axi.wlast   = (state == DATA) && (beat == LAST_BEAT);
  assign sdata_ready = (state == DATA) && axi.wready;

  assign axi.bready  = (outstanding != '0);
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench for cam_frame_writer: expected AW addresses and W beats are queued
// at stimulus time and popped by a monitor as the DUT hands them over.
module tb_cam_frame_writer;
  logic        fclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [23:0] frame_bursts;
  logic [63:0] sdata;
  logic        sdata_valid;
  logic        sdata_burst_valid;
  logic        sdata_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] bursts_done;

  cam_frame_writer_if axi();

  cam_frame_writer #(.BURST_LEN(16), .MAX_OUTSTANDING(4)) dut (
    .fclk              (fclk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .frame_bursts      (frame_bursts),
    .sdata             (sdata),
    .sdata_valid       (sdata_valid),
    .sdata_burst_valid (sdata_burst_valid),
    .sdata_ready       (sdata_ready),
    .axi               (axi.master),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .bursts_done       (bursts_done)
  );

  always #5 fclk = ~fclk;

  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  logic [31:0] exp_aw[$];
  logic [64:0] exp_w[$];
  logic [63:0] stream_cnt;
  logic [63:0] exp_next;

  bit          wready_toggle;
  bit          valid_random;
  bit          b_hold;
  int          b_delay;
  int          b_err_burst;
  int          b_idx;
  int          pend[$];

  int          aw_cnt;
  int          b_cnt;
  int          done_cnt;
  int          beat_cnt;
  int          cyc;
  int          last_b_cyc;
  int          done_gap;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Stream buffer and DDR slave: counter data, optional W stalls, delayed B responses.
  task automatic runEnvironment();
    bit s_hs;
    bit wl_hs;
    bit b_hs;
    forever begin
      @(negedge fclk);
      s_hs  = sdata_valid && sdata_ready;
      wl_hs = axi.wvalid && axi.wready && axi.wlast;
      b_hs  = axi.bvalid && axi.bready;
      @(posedge fclk);
      #1;
      if (s_hs) stream_cnt = stream_cnt + 64'd1;
      sdata = stream_cnt;
      if (!rst_n) begin
        pend.delete();
        axi.bvalid = 1'b0;
      end else begin
        foreach (pend[i]) if (pend[i] > 0) pend[i]--;
        if (wl_hs) pend.push_back(b_delay);
        if (b_hs) begin
          void'(pend.pop_front());
          axi.bvalid = 1'b0;
          b_idx++;
        end
        if (!axi.bvalid && pend.size() > 0 && !b_hold) begin
          if (pend[0] == 0) begin
            axi.bvalid = 1'b1;
            axi.bresp  = (b_idx == b_err_burst) ? 2'b10 : 2'b00;
          end
        end
      end
      sdata_valid = valid_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi.wready  = wready_toggle ? !axi.wready : 1'b1;
    end
  endtask

  task automatic runMonitor();
    logic [64:0] e;
    forever begin
      @(negedge fclk);
      cyc++;
      if (axi.awvalid && axi.awready) begin
        if (exp_aw.size() == 0) begin
          assert_cnt++;
          fail_cnt++;
          $display("[TB] FAIL aw_unexpected: got addr %0h, expected no AW", axi.awaddr);
        end else begin
          checkOutput("aw_addr", axi.awaddr, exp_aw.pop_front());
        end
        checkOutput("aw_len", axi.awlen, 4'd15);
        checkOutput("aw_outstanding_cap", (aw_cnt - b_cnt) < 4, 1);
        aw_cnt++;
      end
      if (axi.wvalid && axi.wready) begin
        if (exp_w.size() == 0) begin
          assert_cnt++;
          fail_cnt++;
          $display("[TB] FAIL w_unexpected: got data %0h, expected no beat", axi.wdata);
        end else begin
          e = exp_w.pop_front();
          checkOutput("w_data", axi.wdata, e[63:0]);
          checkOutput("w_last", axi.wlast, e[64]);
        end
        checkOutput("sdata_ready_follows_wready", sdata_ready, 1);
        beat_cnt++;
      end else if (axi.wvalid && !axi.wready) begin
        checkOutput("sdata_ready_stalled", sdata_ready, 0);
      end
      if (axi.bvalid && axi.bready) begin
        b_cnt++;
        last_b_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_gap = cyc - last_b_cyc;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [23:0] n, input bit expect_frame);
    if (expect_frame) begin
      for (int i = 0; i < int'(n); i++) exp_aw.push_back(b + 32'(i) * 32'd128);
      for (int j = 0; j < int'(n) * 16; j++) begin
        exp_w.push_back({(j % 16) == 15, exp_next});
        exp_next = exp_next + 64'd1;
      end
    end
    b_idx = 0;
    @(negedge fclk);
    start        = 1'b1;
    base_addr    = b;
    frame_bursts = n;
    @(negedge fclk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge fclk);
      n++;
    end
    if (!done) begin
      assert_cnt++;
      fail_cnt++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int aw0;
    int beat0;
    int dc0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    frame_bursts = '0;
    stream_cnt = '0;
    exp_next = '0;
    sdata = '0;
    sdata_valid = 1'b0;
    sdata_burst_valid = 1'b1;
    axi.awready = 1'b1;
    axi.wready = 1'b1;
    axi.bvalid = 1'b0;
    axi.bresp = 2'b00;
    wready_toggle = 1'b0;
    valid_random = 1'b0;
    b_hold = 1'b0;
    b_delay = 2;
    b_err_burst = -1;
    b_idx = 0;
    aw_cnt = 0; b_cnt = 0; done_cnt = 0; beat_cnt = 0;
    cyc = 0; last_b_cyc = 0; done_gap = 0;
    fork
      runEnvironment();
      runMonitor();
    join_none

    repeat (3) @(negedge fclk);
    checkOutput("rst_awvalid", axi.awvalid, 0);
    checkOutput("rst_awaddr", axi.awaddr, 0);
    checkOutput("rst_wvalid", axi.wvalid, 0);
    checkOutput("rst_wlast", axi.wlast, 0);
    checkOutput("rst_bready", axi.bready, 0);
    checkOutput("rst_sdata_ready", sdata_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_bursts_done", bursts_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge fclk);

    $display("[TB] nominal frame");
    aw0 = aw_cnt; beat0 = beat_cnt; dc0 = done_cnt;
    applyStimulus(32'h1000_0000, 24'd3, 1'b1);
    checkOutput("nom_busy_after_start", busy, 1);
    waitDone(400);
    checkOutput("nom_bursts_done", bursts_done, 3);
    checkOutput("nom_err", err, 0);
    checkOutput("nom_busy_during_done", busy, 1);
    @(negedge fclk);
    checkOutput("nom_done_after_last_b", done_gap, 1);
    checkOutput("nom_busy_low", busy, 0);
    checkOutput("nom_done_single", done, 0);
    checkOutput("nom_done_count", done_cnt - dc0, 1);
    checkOutput("nom_aw_count", aw_cnt - aw0, 3);
    checkOutput("nom_beat_count", beat_cnt - beat0, 48);
    checkOutput("nom_aw_left", exp_aw.size(), 0);
    checkOutput("nom_w_left", exp_w.size(), 0);

    $display("[TB] start while busy");
    applyStimulus(32'h2000_0000, 24'd2, 1'b1);
    repeat (5) @(negedge fclk);
    start = 1'b1;
    base_addr = 32'h3000_0040;
    frame_bursts = 24'd5;
    @(negedge fclk);
    start = 1'b0;
    waitDone(400);
    checkOutput("busy_start_bursts_done", bursts_done, 2);
    checkOutput("busy_start_err", err, 0);
    @(negedge fclk);
    checkOutput("busy_start_aw_left", exp_aw.size(), 0);
    checkOutput("busy_start_w_left", exp_w.size(), 0);

    $display("[TB] backpressure");
    wready_toggle = 1'b1;
    valid_random = 1'b1;
    applyStimulus(32'h2000_0F80, 24'd3, 1'b1);
    waitDone(1500);
    checkOutput("bp_bursts_done", bursts_done, 3);
    wready_toggle = 1'b0;
    valid_random = 1'b0;
    @(negedge fclk);
    checkOutput("bp_w_left", exp_w.size(), 0);

    $display("[TB] outstanding cap with address wrap");
    b_hold = 1'b1;
    aw0 = aw_cnt;
    applyStimulus(32'hFFFF_FE00, 24'd8, 1'b1);
    repeat (150) @(negedge fclk);
    checkOutput("cap_aw_before_b", aw_cnt - aw0, 4);
    checkOutput("cap_awvalid_blocked", axi.awvalid, 0);
    checkOutput("cap_bready", axi.bready, 1);
    b_hold = 1'b0;
    waitDone(1500);
    checkOutput("cap_bursts_done", bursts_done, 8);
    @(negedge fclk);
    checkOutput("cap_aw_left", exp_aw.size(), 0);
    checkOutput("cap_w_left", exp_w.size(), 0);

    $display("[TB] bad response");
    b_err_burst = 1;
    applyStimulus(32'h1000_2000, 24'd4, 1'b1);
    waitDone(600);
    checkOutput("bresp_err", err, 1);
    checkOutput("bresp_bursts_done", bursts_done, 4);
    b_err_burst = -1;
    repeat (5) @(negedge fclk);
    checkOutput("bresp_err_sticky", err, 1);
    checkOutput("bresp_w_left", exp_w.size(), 0);

    $display("[TB] misaligned base");
    aw0 = aw_cnt;
    applyStimulus(32'h1000_0040, 24'd2, 1'b0);
    checkOutput("misalign_done", done, 1);
    checkOutput("misalign_err", err, 1);
    checkOutput("misalign_busy", busy, 0);
    repeat (10) @(negedge fclk);
    checkOutput("misalign_no_aw", aw_cnt - aw0, 0);

    $display("[TB] zero-length frame");
    applyStimulus(32'h1000_0000, 24'd0, 1'b0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_err_cleared", err, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("zero_busy", busy, 0);
      @(negedge fclk);
    end
    checkOutput("zero_done_single", done, 0);

    $display("[TB] reset mid-burst");
    beat0 = beat_cnt;
    applyStimulus(32'h4000_0000, 24'd2, 1'b1);
    n = 0;
    while ((beat_cnt - beat0) < 7 && n < 200) begin
      @(negedge fclk);
      n++;
    end
    checkOutput("rst_mid_reached_beat7", (beat_cnt - beat0) >= 7, 1);
    @(posedge fclk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wvalid", axi.wvalid, 0);
    checkOutput("rst_mid_awvalid", axi.awvalid, 0);
    checkOutput("rst_mid_sdata_ready", sdata_ready, 0);
    checkOutput("rst_mid_bready", axi.bready, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_bursts_done", bursts_done, 0);
    exp_aw.delete();
    exp_w.delete();
    @(negedge fclk);
    aw_cnt = 0;
    b_cnt = 0;
    rst_n = 1'b1;
    @(negedge fclk);
    exp_next = stream_cnt;
    applyStimulus(32'h5000_0000, 24'd1, 1'b1);
    waitDone(400);
    checkOutput("post_rst_bursts_done", bursts_done, 1);
    checkOutput("post_rst_err", err, 0);
    @(negedge fclk);
    checkOutput("post_rst_aw_left", exp_aw.size(), 0);
    checkOutput("post_rst_w_left", exp_w.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
